inst_buffer: RTL and testbench

Circular instruction queue between the 4-way instruction cache and the decode stage. It accepts fetch packets of up to four 32-bit instructions per cycle and strips the words that precede the fetch PC in the line. It presents one or two in-order instructions per cycle to decode, with their PC and branch-prediction sidecar, and applies backpressure to the cache through `ib_allin`.

---
 rtl/inst_buffer_pkg.sv | 11 +
 rtl/inst_buffer_entry_ram.sv | 54 +++++
 rtl/inst_buffer.sv | 116 +++++++++++
 tb/tb_inst_buffer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/inst_buffer_pkg.sv
// inst_buffer_pkg: shared entry field widths, fetch width and fetch-word PC helper.
package inst_buffer_pkg;
  localparam int FETCH_WORDS = 4;
  localparam int INST_W = 32;
  localparam int PC_W = 32;
  localparam int DELOT_W = 1;
  localparam int PtabAddrBus = 4;
  function automatic logic [PC_W-1:0] word_pc(input logic [PC_W-1:0] pc, input logic [1:0] k);
    return {pc[PC_W-1:4], 4'h0} + {28'd0, k, 2'b00};
  endfunction
endpackage

// File: rtl/inst_buffer_entry_ram.sv
// ib_entry_ram: DEPTH-entry register file, 4 write ports at consecutive indices, 2 async read ports.
module ib_entry_ram
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTAB_W = PtabAddrBus,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic [FETCH_WORDS-1:0]         we_i,
  input  logic [AW-1:0]                  waddr_i,
  input  logic [FETCH_WORDS*INST_W-1:0]  winst_i,
  input  logic [FETCH_WORDS*PC_W-1:0]    wpc_i,
  input  logic [PTAB_W-1:0]              wptab_i,
  input  logic [FETCH_WORDS-1:0]         wdelot_i,
  input  logic [PC_W-1:0]                wbpc_i,
  input  logic [AW-1:0]                  raddr0_i,
  input  logic [AW-1:0]                  raddr1_i,
  output logic [INST_W-1:0]              rinst0_o,
  output logic [PC_W-1:0]                rpc0_o,
  output logic [PTAB_W-1:0]              rptab0_o,
  output logic                           rdelot0_o,
  output logic [PC_W-1:0]                rbpc0_o,
  output logic [INST_W-1:0]              rinst1_o,
  output logic [PC_W-1:0]                rpc1_o,
  output logic [PTAB_W-1:0]              rptab1_o,
  output logic                           rdelot1_o,
  output logic [PC_W-1:0]                rbpc1_o
);
  logic [INST_W-1:0] inst_q  [DEPTH];
  logic [PC_W-1:0]   pc_q    [DEPTH];
  logic [PTAB_W-1:0] ptab_q  [DEPTH];
  logic              delot_q [DEPTH];
  logic [PC_W-1:0]   bpc_q   [DEPTH];
  always_ff @(posedge clk)
    for (int i = 0; i < FETCH_WORDS; i++)
      if (we_i[i]) begin
        inst_q[AW'(waddr_i + AW'(i))]  <= winst_i[INST_W*i +: INST_W];
        pc_q[AW'(waddr_i + AW'(i))]    <= wpc_i[PC_W*i +: PC_W];
        ptab_q[AW'(waddr_i + AW'(i))]  <= wptab_i;
        delot_q[AW'(waddr_i + AW'(i))] <= wdelot_i[i];
        bpc_q[AW'(waddr_i + AW'(i))]   <= wbpc_i;
      end
  assign rinst0_o  = inst_q[raddr0_i];
  assign rpc0_o    = pc_q[raddr0_i];
  assign rptab0_o  = ptab_q[raddr0_i];
  assign rdelot0_o = delot_q[raddr0_i];
  assign rbpc0_o   = bpc_q[raddr0_i];
  assign rinst1_o  = inst_q[raddr1_i];
  assign rpc1_o    = pc_q[raddr1_i];
  assign rptab1_o  = ptab_q[raddr1_i];
  assign rdelot1_o = delot_q[raddr1_i];
  assign rbpc1_o   = bpc_q[raddr1_i];
endmodule

// File: rtl/inst_buffer.sv
// inst_buffer: circular fetch-to-decode instruction queue.
// Second issue slot enabled by defining IB_DUAL_ISSUE_EN; otherwise slot 1 is tied off.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTAB_W = PtabAddrBus
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          icache_ns,
  input  logic [FETCH_WORDS*INST_W-1:0] icache_rd_data,
  input  logic [PC_W-1:0]               cpu_rd_pc,
  input  logic [PTAB_W-1:0]             icache_ib_ptab,
  input  logic                          icache_ib_delot_en,
  input  logic [PC_W-1:0]               icache_ib_branch_pc,
  output logic                          ib_allin,
  input  logic                          id_allin,
  output logic                          ib_valid0,
  output logic                          ib_valid1,
  output logic [INST_W-1:0]             ib_inst0,
  output logic [INST_W-1:0]             ib_inst1,
  output logic [PC_W-1:0]               ib_pc0,
  output logic [PC_W-1:0]               ib_pc1,
  output logic [PTAB_W-1:0]             ib_ptab0,
  output logic [PTAB_W-1:0]             ib_ptab1,
  output logic                          ib_delot0,
  output logic                          ib_delot1,
  output logic [PC_W-1:0]               ib_branch_pc0,
  output logic [PC_W-1:0]               ib_branch_pc1
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, head1;
  logic [AW:0] count_q, count_d;
  logic [1:0] off;
  logic [2:0] n_push, n_pop;
  logic push, v0, v1;
  logic [FETCH_WORDS-1:0] we;
  logic [FETCH_WORDS*INST_W-1:0] winst;
  logic [FETCH_WORDS*PC_W-1:0] wpc;
  logic [INST_W-1:0] rinst0, rinst1;
  logic [PC_W-1:0] rpc0, rpc1, rbpc0, rbpc1;
  logic [PTAB_W-1:0] rptab0, rptab1;
  logic rdelot0, rdelot1;
  assign off = cpu_rd_pc[3:2];
  assign ib_allin = (AW+1)'(DEPTH) - count_q >= (AW+1)'(FETCH_WORDS);
  assign v0 = count_q != '0;
`ifdef IB_DUAL_ISSUE_EN
  assign v1 = count_q > (AW+1)'(1);
`else
  assign v1 = 1'b0;
`endif
  // a packet arriving with flush is dropped, so it never reaches storage either
  assign push = icache_ns && ib_allin && !flush;
  assign n_push = push ? 3'd4 - {1'b0, off} : 3'd0;
  assign n_pop = id_allin ? {2'b0, v0} + {2'b0, v1} : 3'd0;
  assign head1 = head_q + AW'(1);
  for (genvar w = 0; w < FETCH_WORDS; w++) begin : g_wr
    logic [1:0] src;
    assign src = off + 2'(w);
    assign we[w] = push && (3'(off) + 3'(w) < 3'(FETCH_WORDS));
    assign winst[INST_W*w +: INST_W] = icache_rd_data[INST_W*src +: INST_W];
    assign wpc[PC_W*w +: PC_W] = word_pc(cpu_rd_pc, src);
  end
  always_comb begin
    head_d  = flush ? '0 : head_q + AW'(n_pop);
    tail_d  = flush ? '0 : tail_q + AW'(n_push);
    count_d = flush ? '0 : count_q + (AW+1)'(n_push) - (AW+1)'(n_pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  ib_entry_ram #(.DEPTH(DEPTH), .PTAB_W(PTAB_W)) u_ram (
    .clk       (clk),
    .we_i      (we),
    .waddr_i   (tail_q),
    .winst_i   (winst),
    .wpc_i     (wpc),
    .wptab_i   (icache_ib_ptab),
    .wdelot_i  ({3'b000, icache_ib_delot_en}),
    .wbpc_i    (icache_ib_branch_pc),
    .raddr0_i  (head_q),
    .raddr1_i  (head1),
    .rinst0_o  (rinst0),
    .rpc0_o    (rpc0),
    .rptab0_o  (rptab0),
    .rdelot0_o (rdelot0),
    .rbpc0_o   (rbpc0),
    .rinst1_o  (rinst1),
    .rpc1_o    (rpc1),
    .rptab1_o  (rptab1),
    .rdelot1_o (rdelot1),
    .rbpc1_o   (rbpc1)
  );
  assign ib_valid0     = v0;
  assign ib_inst0      = v0 ? rinst0 : '0;
  assign ib_pc0        = v0 ? rpc0 : '0;
  assign ib_ptab0      = v0 ? rptab0 : '0;
  assign ib_delot0     = v0 && rdelot0;
  assign ib_branch_pc0 = v0 ? rbpc0 : '0;
  assign ib_valid1     = v1;
  assign ib_inst1      = v1 ? rinst1 : '0;
  assign ib_pc1        = v1 ? rpc1 : '0;
  assign ib_ptab1      = v1 ? rptab1 : '0;
  assign ib_delot1     = v1 && rdelot1;
  assign ib_branch_pc1 = v1 ? rbpc1 : '0;
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: directed self-checking bench for inst_buffer (either IB_DUAL_ISSUE_EN build).
module tb_inst_buffer;
`ifdef IB_DUAL_ISSUE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, flush, icache_ns, icache_ib_delot_en, id_allin;
  logic [127:0] icache_rd_data;
  logic [31:0] cpu_rd_pc, icache_ib_branch_pc;
  logic [3:0] icache_ib_ptab;
  logic ib_allin, ib_valid0, ib_valid1, ib_delot0, ib_delot1;
  logic [31:0] ib_inst0, ib_inst1, ib_pc0, ib_pc1, ib_branch_pc0, ib_branch_pc1;
  logic [3:0] ib_ptab0, ib_ptab1;
  int tests = 0, fails = 0;
  logic [63:0] q[$];
  always #5 clk = ~clk;
  inst_buffer dut (
    .clk(clk), .reset(reset), .flush(flush), .icache_ns(icache_ns),
    .icache_rd_data(icache_rd_data), .cpu_rd_pc(cpu_rd_pc), .icache_ib_ptab(icache_ib_ptab),
    .icache_ib_delot_en(icache_ib_delot_en), .icache_ib_branch_pc(icache_ib_branch_pc),
    .ib_allin(ib_allin), .id_allin(id_allin),
    .ib_valid0(ib_valid0), .ib_valid1(ib_valid1), .ib_inst0(ib_inst0), .ib_inst1(ib_inst1),
    .ib_pc0(ib_pc0), .ib_pc1(ib_pc1), .ib_ptab0(ib_ptab0), .ib_ptab1(ib_ptab1),
    .ib_delot0(ib_delot0), .ib_delot1(ib_delot1),
    .ib_branch_pc0(ib_branch_pc0), .ib_branch_pc1(ib_branch_pc1)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // queue the words a packet at pc should contribute, in order
  task automatic mpush(input logic [31:0] pc, input logic [31:0] base);
    for (int k = int'(pc[3:2]); k < 4; k++)
      q.push_back({base + 32'(k), {pc[31:4], 4'h0} + 32'(4 * k)});
  endtask
  task automatic drive(input logic [31:0] pc, input logic [31:0] base);
    icache_ns = 1'b1;
    cpu_rd_pc = pc;
    icache_rd_data = {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endtask
  task automatic push(input logic [31:0] pc, input logic [31:0] base);
    drive(pc, base);
    tick();
    icache_ns = 1'b0;
    mpush(pc, base);
  endtask
  task automatic drain_chk(input string tag);
    logic [63:0] e1;
    id_allin = 1'b1;
    while (q.size() > 0) begin
      e1 = (DUAL && q.size() > 1) ? q[1] : 64'd0;
      chk({tag, " v0"}, 64'(ib_valid0), 64'd1);
      chk({tag, " s0"}, {ib_inst0, ib_pc0}, q[0]);
      chk({tag, " v1"}, 64'(ib_valid1), 64'(DUAL && q.size() > 1));
      chk({tag, " s1"}, {ib_inst1, ib_pc1}, e1);
      tick();
      if (DUAL && q.size() > 1) void'(q.pop_front());
      void'(q.pop_front());
    end
    chk({tag, " empty"}, 64'(ib_valid0), 64'd0);
    id_allin = 1'b0;
  endtask
  initial begin
    reset = 1'b1; flush = 1'b0; icache_ns = 1'b0; icache_ib_delot_en = 1'b0; id_allin = 1'b0;
    icache_rd_data = '0; cpu_rd_pc = '0; icache_ib_branch_pc = '0; icache_ib_ptab = '0;
    repeat (2) tick();
    reset = 1'b0;
    chk("rst v0", 64'(ib_valid0), 64'd0);
    chk("rst v1", 64'(ib_valid1), 64'd0);
    chk("rst allin", 64'(ib_allin), 64'd1);
    chk("rst data0", {ib_inst0, ib_pc0}, 64'd0);
    chk("rst side0", {ib_branch_pc0, 27'd0, ib_delot0, ib_ptab0}, 64'd0);
    // aligned packet, decode stalled
    icache_ib_ptab = 4'h5; icache_ib_branch_pc = 32'h0000_2000;
    push(32'h0000_1000, 32'hA000_0000);
    chk("al count", 64'(dut.count_q), 64'd4);
    chk("al ptab0", 64'(ib_ptab0), 64'h5);
    chk("al bpc0", 64'(ib_branch_pc0), 64'h2000);
    chk("al delot0", 64'(ib_delot0), 64'd0);
    chk("al ptab1", 64'(ib_ptab1), DUAL ? 64'h5 : 64'h0);
    drain_chk("al drain");
    // offset packet with delay-slot flag
    icache_ib_ptab = 4'h3; icache_ib_branch_pc = 32'h0000_3000; icache_ib_delot_en = 1'b1;
    push(32'h0000_1008, 32'hB000_0000);
    icache_ib_delot_en = 1'b0;
    chk("off count", 64'(dut.count_q), 64'd2);
    chk("off s0", {ib_inst0, ib_pc0}, {32'hB000_0002, 32'h0000_1008});
    chk("off delot0", 64'(ib_delot0), 64'd1);
    chk("off s1", {ib_inst1, ib_pc1}, DUAL ? {32'hB000_0003, 32'h0000_100C} : 64'd0);
    chk("off delot1", 64'(ib_delot1), 64'd0);
    chk("off bpc1", 64'(ib_branch_pc1), DUAL ? 64'h3000 : 64'h0);
    // fill to 13 with decode stalled
    push(32'h0000_2000, 32'hC000_0000);
    push(32'h0000_3000, 32'hD000_0000);
    chk("fill10 count", 64'(dut.count_q), 64'd10);
    chk("fill10 allin", 64'(ib_allin), 64'd1);
    push(32'h0000_4004, 32'hE000_0000);
    chk("fill13 count", 64'(dut.count_q), 64'd13);
    chk("fill13 allin", 64'(ib_allin), 64'd0);
    drive(32'h0000_5000, 32'hF000_0000);
    tick();
    icache_ns = 1'b0;
    chk("full reject count", 64'(dut.count_q), 64'd13);
    chk("full reject s0", {ib_inst0, ib_pc0}, {32'hB000_0002, 32'h0000_1008});
    id_allin = 1'b1;
    tick();
    id_allin = 1'b0;
    if (DUAL) void'(q.pop_front());
    void'(q.pop_front());
    chk("pop allin", 64'(ib_allin), 64'd1);
    chk("pop count", 64'(dut.count_q), DUAL ? 64'd11 : 64'd12);
    chk("pop s0", {ib_inst0, ib_pc0}, q[0]);
    // flush with a packet in the same cycle
    flush = 1'b1;
    drive(32'h0000_6000, 32'h6000_0000);
    tick();
    flush = 1'b0; icache_ns = 1'b0;
    q.delete();
    chk("flush count", 64'(dut.count_q), 64'd0);
    chk("flush v0", 64'(ib_valid0), 64'd0);
    chk("flush v1", 64'(ib_valid1), 64'd0);
    chk("flush allin", 64'(ib_allin), 64'd1);
    chk("flush data0", {ib_inst0, ib_pc0}, 64'd0);
    // walk pointers to head = tail = 14
    for (int i = 0; i < 3; i++) begin
      push(32'h0000_7000 + 32'(i * 16), 32'h7000_0000 + 32'(i * 16));
      drain_chk("walk");
    end
    push(32'h0000_7038, 32'h7000_0030);
    drain_chk("walk2");
    // head = 14, count = 2, then push 4 and pop in the same cycle across the wrap
    push(32'h0000_8008, 32'h8000_0000);
    chk("wrap pre count", 64'(dut.count_q), 64'd2);
    chk("wrap pre s0", {ib_inst0, ib_pc0}, {32'h8000_0002, 32'h0000_8008});
    drive(32'h0000_9000, 32'h9000_0000);
    id_allin = 1'b1;
    tick();
    icache_ns = 1'b0; id_allin = 1'b0;
    if (DUAL) void'(q.pop_front());
    void'(q.pop_front());
    mpush(32'h0000_9000, 32'h9000_0000);
    chk("wrap count", 64'(dut.count_q), DUAL ? 64'd4 : 64'd5);
    chk("wrap head", 64'(dut.head_q), DUAL ? 64'd0 : 64'd15);
    drain_chk("wrap drain");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
